// File: rtl/twiddle_mult.sv
// twiddle_mult: complex sample x twiddle multiplier, 3-stage pipeline.
// out = in * coeff, scaled by 2^-9 with round-half-up, Q1.9 coefficients.
// A frame-position sof flag travels with each sample.
// Optional macro TWIDDLE_SAT_EN: clamp results to DW bits and raise sticky ovf;
// without it results wrap to DW bits and ovf is tied low.
`timescale 1ns/1ps
module twiddle_mult #(
  parameter int DW    = 16,
  parameter int CW    = 11,
  parameter int FRAME = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2*DW-1:0] in_data,
  input  logic [2*CW-1:0] coeff_in,
  output logic            out_valid,
  output logic [2*DW-1:0] out_data,
  output logic            out_sof,
  output logic            ovf
);

  localparam int IW = $clog2(FRAME);
  localparam int PW = DW + CW;   // single product width
  localparam int SW = PW + 1;    // sum of two products
  localparam int RW = SW - 9;    // width after the 2^-9 scale

  // Round-half-up then drop the nine Q1.9 fraction bits.
  function automatic logic signed [RW-1:0] round_q9(input logic signed [SW-1:0] s);
    return RW'((s + SW'(256)) >>> 9);
  endfunction

`ifdef TWIDDLE_SAT_EN
  // True when x does not fit in a signed DW-bit result.
  function automatic logic over_dw(input logic signed [RW-1:0] x);
    return x[RW-1:DW-1] != {(RW-DW+1){x[DW-1]}};
  endfunction

  // Clamp x to the signed DW-bit range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [RW-1:0] x);
    if (!over_dw(x)) return DW'(x);
    return x[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction
`else
  // Keep the low DW bits (two's complement wrap).
  function automatic logic signed [DW-1:0] wrap_dw(input logic signed [RW-1:0] x);
    return DW'(x);
  endfunction
`endif

  logic [IW-1:0]          idx_q, idx_d;
  logic                   vld_p0, vld_p1, vld_p2;
  logic                   sof_p0, sof_p1, sof_p2;
  logic signed [DW-1:0]   a_p0, b_p0;
  logic signed [CW-1:0]   c_p0, d_p0;
  logic signed [PW-1:0]   ac_p1, bd_p1, ad_p1, bc_p1;
  logic signed [SW-1:0]   re_sum, im_sum;
  logic signed [RW-1:0]   re_rnd, im_rnd;
  logic signed [DW-1:0]   re_lim, im_lim;
  logic [2*DW-1:0]        out_q;

  // Frame index advances only on accepted samples; power-of-two FRAME wraps naturally.
  always_comb begin
    idx_d = idx_q;
    if (in_valid) idx_d = idx_q + IW'(1);
  end

  // Control path: valid/sof shift register and the frame index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      sof_p0 <= 1'b0;
      sof_p1 <= 1'b0;
      sof_p2 <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      vld_p0 <= in_valid;
      sof_p0 <= in_valid && (idx_q == '0);
      vld_p1 <= vld_p0;
      sof_p1 <= sof_p0;
      vld_p2 <= vld_p1;
      sof_p2 <= sof_p1;
    end
  end

  // S1: capture operands of accepted samples.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      a_p0 <= signed'(in_data[2*DW-1:DW]);
      b_p0 <= signed'(in_data[DW-1:0]);
      c_p0 <= signed'(coeff_in[2*CW-1:CW]);
      d_p0 <= signed'(coeff_in[CW-1:0]);
    end
  end

  // S2: the four full-precision partial products.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      ac_p1 <= PW'(a_p0) * PW'(c_p0);
      bd_p1 <= PW'(b_p0) * PW'(d_p0);
      ad_p1 <= PW'(a_p0) * PW'(d_p0);
      bc_p1 <= PW'(b_p0) * PW'(c_p0);
    end
  end

  // Combine products, round and limit ahead of the output register.
  always_comb begin
    re_sum = SW'(ac_p1) - SW'(bd_p1);
    im_sum = SW'(ad_p1) + SW'(bc_p1);
    re_rnd = round_q9(re_sum);
    im_rnd = round_q9(im_sum);
`ifdef TWIDDLE_SAT_EN
    re_lim = sat_dw(re_rnd);
    im_lim = sat_dw(im_rnd);
`else
    re_lim = wrap_dw(re_rnd);
    im_lim = wrap_dw(im_rnd);
`endif
  end

  // S3: output data register, cleared by reset and held while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        out_q <= '0;
    else if (vld_p1) out_q <= {re_lim, im_lim};
  end

`ifdef TWIDDLE_SAT_EN
  logic ovf_q;

  // Sticky overflow: set on any clamp of a valid result, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else if (vld_p1 && (over_dw(re_rnd) || over_dw(im_rnd))) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = vld_p2;
  assign out_data  = out_q;
  assign out_sof   = sof_p2 & vld_p2;

endmodule

// File: tb/tb_twiddle_mult.sv
// Self-checking bench for twiddle_mult (defaults DW=16, CW=11, FRAME=32).
// Expected results are queued when a sample is driven and compared on output.
`timescale 1ns/1ps
module tb_twiddle_mult;

  localparam int DW = 16;
  localparam int CW = 11;
  localparam int FRAME = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [2*DW-1:0] in_data;
  logic [2*CW-1:0] coeff_in;
  logic            out_valid;
  logic [2*DW-1:0] out_data;
  logic            out_sof;
  logic            ovf;

  twiddle_mult #(.DW(DW), .CW(CW), .FRAME(FRAME)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .coeff_in (coeff_in),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sof  (out_sof),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     re;
    int     im;
    bit     sof;
    longint due;
  } exp_t;

  exp_t   sb[$];
  longint cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  int     tb_idx = 0;
  bit     exp_ovf = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scale a full-precision sum and limit it to DW bits.
  task automatic lim(input longint s, output int r, output bit o);
    longint v;
    logic [15:0] lo;
    v = (s + 256) >>> 9;
    o = 1'b0;
`ifdef TWIDDLE_SAT_EN
    if (v > 32767) begin r = 32767; o = 1'b1; end
    else if (v < -32768) begin r = -32768; o = 1'b1; end
    else r = int'(v);
`else
    lo = v[15:0];
    r = int'($signed(lo));
`endif
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    exp_t e;
    bit o1, o2;
    longint rs, is;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {a[15:0], b[15:0]};
    coeff_in = {c[10:0], d[10:0]};
    rs = longint'(a) * c - longint'(b) * d;
    is = longint'(a) * d + longint'(b) * c;
    lim(rs, e.re, o1);
    lim(is, e.im, o2);
    if (o1 || o2) exp_ovf = 1'b1;
    e.sof = (tb_idx == 0);
    tb_idx = (tb_idx + 1) % FRAME;
    e.due = cyc + 3;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      coeff_in = 22'($urandom);
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    tb_idx = 0;
    exp_ovf = 1'b0;
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sof", out_sof, 0);
    chk("rst_ovf", ovf, 0);
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  // Output monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [2*DW-1:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        last = '0;
        chk("rst_vld_hold", out_valid, 0);
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("stale_valid", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("re", $signed(out_data[2*DW-1:DW]), e.re);
          chk("im", $signed(out_data[DW-1:0]), e.im);
          chk("sof", out_sof, e.sof);
          chk("latency", cyc, e.due);
        end
        last = out_data;
      end else begin
        chk("hold", out_data, last);
        chk("sof_idle", out_sof, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    coeff_in = '0;
    do_reset(3);

    // Identity coefficient, first sample after reset carries sof.
    send(1000, 0, 512, 0);
    idle(2);
    // Multiply by -j.
    send(1000, 200, 0, -512);
    // Rounding of exact halves, back to back.
    send(1, 0, 256, 0);
    send(-1, 0, 256, 0);
    drain();
    chk("ovf_before", ovf, exp_ovf);

    // Extreme product: clamps or wraps depending on build.
    send(32767, 32767, 512, -512);
    drain();
    chk("ovf_after", ovf, exp_ovf);
    chk("ovf_sticky_model", ovf, `ifdef TWIDDLE_SAT_EN 1 `else 0 `endif);

    // 33 random samples with random single-cycle gaps, starting a fresh frame.
    do_reset(2);
    for (int i = 0; i < 33; i++) begin
      send(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
           int'($urandom_range(1024)) - 512, int'($urandom_range(1024)) - 512);
      if ($urandom_range(1) == 1) idle(1);
    end
    drain();

    // Reset in mid-frame with samples in flight.
    for (int i = 0; i < 10; i++)
      send(100 * i, -50 * i, 300, -100);
    do_reset(2);
    send(-1234, 777, 400, 123);
    send(5, -5, -512, 511);
    drain();
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/twiddle_mult.md
TWIDDLE_MULT -- requirements
Module: twiddle_mult

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed bit width of each real/imag data component.
REQ-002 SHALL have parameter CW, default 11, meaning signed coefficient component width, Q1.9 format (512 = +1.0).
REQ-003 SHALL have parameter FRAME, default 32, meaning samples per coefficient frame; power of two.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  qualifies in_data and coeff_in in the same cycle.
REQ-007 SHALL have port in_data  input  2*DW  {re[2*DW-1:DW], im[DW-1:0]}, two's complement.
REQ-008 SHALL have port coeff_in  input  2*CW  twiddle from the coefficient ROM stage, {re[2*CW-1:CW], im[CW-1:0]}.
REQ-009 SHALL have port out_valid  output  1  qualifies out_data.
REQ-010 SHALL have port out_data  output  2*DW  product, same packing as in_data.
REQ-011 SHALL have port out_sof  output  1  high with out_valid on the output of frame index 0.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-013 SHALL compute re = a*c - b*d and im = a*d + b*c for in_data (a+jb) and coeff_in (c+jd), at full precision (2 products of DW+CW bits; sum of DW+CW+1 bits).
REQ-014 SHALL scale each sum by 2^-9 using round-half-up: add 256, then arithmetic shift right by 9.
REQ-015 SHALL be a 3-stage pipeline: S1 registers inputs; S2 registers the four products; S3 registers the rounded/limited sums. Latency from in_valid to out_valid is exactly 3 cycles.
REQ-016 SHALL accept one sample per cycle; in_valid gaps of any length are allowed, and each stage passes a valid bit alongside its data.
REQ-017 SHALL leave data registers unchanged in stages whose valid is low; out_data holds its last value while out_valid is low.
REQ-018 SHALL keep a log2(FRAME)-bit sample index that increments on each accepted input, wraps FRAME-1 -> 0, and does not advance without in_valid.
REQ-019 SHALL carry a sof bit through the pipeline, set when the index equals 0 at acceptance; out_sof = stage-3 sof AND out_valid.
REQ-020 SHALL consume coeff_in only in cycles where in_valid is high; alignment of coeff_in with in_data is the upstream stage's responsibility.

Reset
REQ-021 SHALL, while rst is low, asynchronously clear all valid bits, the sample index, all sof bits, out_data (to 0) and ovf.
REQ-022 SHALL discard samples in flight when reset is asserted mid-frame; the first accepted sample after release is index 0.
REQ-023 SHALL accept input on the first rising clk edge after rst deasserts.

Configuration
REQ-024 SHALL, with macro TWIDDLE_SAT_EN defined, clamp each scaled result to [-2^(DW-1), 2^(DW-1)-1] and set ovf on any clamp; ovf stays set until reset.
REQ-025 SHALL, without TWIDDLE_SAT_EN, truncate each scaled result to its low DW bits (wrap-around), with ovf tied to 0.

Verification
REQ-026 SHALL pass this case: in (1000,0), coeff (512,0) -> out (1000,0) exactly 3 cycles later, out_sof=1 (first sample after reset).
REQ-027 SHALL pass this case: in (1000,200), coeff (0,-512) -> out (200,-1000).
REQ-028 SHALL pass this case: in (1,0), coeff (256,0) -> out (1,0) (half rounds up); in (-1,0), coeff (256,0) -> out (0,0).
REQ-029 SHALL pass this case: in (32767,32767), coeff (512,-512) -> with TWIDDLE_SAT_EN out (32767,0) and ovf=1; without it, out (-2,0) and ovf=0.
REQ-030 SHALL pass this case: 33 valid inputs with random single-cycle in_valid gaps -> out_sof on output 1 and output 33 only, and output order is preserved.
REQ-031 SHALL pass this case: reset pulsed low after 10 accepted samples -> out_valid drops immediately and no stale outputs appear; the next accepted sample emerges with out_sof=1.
